fifo_drain_ctrl: RTL

Parametrised multi-channel read controller that drains CH FIFOs into a single shared read port. Each channel arms on full or on a high watermark and stays armed until empty or a low watermark (hysteresis). Armed channels are served round-robin in bursts of at most BURST reads, then the controller re-arbitrates. Sits between the per-channel FIFO status flags and the shared downstream consumer.

---
 rtl/fifo_drain_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fifo_drain_ctrl.sv
// Round-robin burst drain controller: CH FIFOs with watermark hysteresis share one read port.
// Optional read statistics counter is built when FIFO_DRAIN_STATS_EN is defined.
module fifo_drain_ctrl #(
  parameter int CH    = 4,
  parameter int LVL_W = 8,
  parameter int HI_WM = 192,
  parameter int LO_WM = 0,
  parameter int BURST = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic [CH-1:0]                      read_full,
  input  logic [CH-1:0]                      read_empty,
  input  logic [CH*LVL_W-1:0]                level,
`ifdef FIFO_DRAIN_STATS_EN
  input  logic                               stat_clr,
  output logic [31:0]                        read_cnt,
`endif
  output logic [CH-1:0]                      read_req,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] active_ch,
  output logic                               busy
);

  localparam int AW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW = $clog2(BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [31:0] HI_V = 32'(HI_WM);
  localparam logic [31:0] LO_V = 32'(LO_WM);

  logic [0:0]    state_r;
  logic [CH-1:0] pending_r;
  logic [CH-1:0] pending_nxt_s;
  logic [AW-1:0] active_ch_r;
  logic [AW-1:0] rr_r;
  logic [CW-1:0] burst_cnt_r;
  logic [31:0]   lvl_s;
  logic [AW-1:0] idx_s;
  logic [AW-1:0] pick_s;
  logic          found_s;
  logic          rd_s;
  logic          last_s;
  logic          exit_s;

  // Arm/disarm hysteresis per channel; full dominates empty.
  always_comb begin
    pending_nxt_s = pending_r;
    lvl_s         = 32'h0;
    for (int i = 0; i < CH; i++) begin
      lvl_s = 32'(level[i*LVL_W +: LVL_W]);
      if (read_full[i] || (lvl_s >= HI_V)) begin
        pending_nxt_s[i] = 1'b1;
      end else if (read_empty[i] || (lvl_s <= LO_V)) begin
        pending_nxt_s[i] = 1'b0;
      end else begin
        pending_nxt_s[i] = pending_r[i];
      end
    end
  end

  // First pending channel strictly after the round-robin pointer, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int k = 1; k <= CH; k++) begin
      idx_s   = AW'((int'(rr_r) + k) % CH);
      pick_s  = (!found_s && pending_r[idx_s]) ? idx_s : pick_s;
      found_s = found_s | pending_r[idx_s];
    end
  end

  assign rd_s   = (state_r == ST_DRAIN) & enable & pending_r[active_ch_r] & ~read_empty[active_ch_r];
  assign last_s = (burst_cnt_r == CW'(BURST - 1));
  assign exit_s = ~enable | read_empty[active_ch_r] | ~pending_nxt_s[active_ch_r] | (rd_s & last_s);

  // Read strobe is combinational so it can drop in the same cycle as enable or empty.
  always_comb begin
    if (rd_s) begin
      read_req = CH'(1'b1) << active_ch_r;
    end else begin
      read_req = '0;
    end
  end

  assign active_ch = active_ch_r;
  assign busy      = (state_r == ST_DRAIN);

  // Pending flags track the FIFO status every edge, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Grant/drain state machine; every re-grant passes through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      active_ch_r <= '0;
      rr_r        <= AW'(CH - 1);
      burst_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable && found_s) begin
            state_r     <= ST_DRAIN;
            active_ch_r <= pick_s;
            rr_r        <= pick_s;
            burst_cnt_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (rd_s) begin
            burst_cnt_r <= burst_cnt_r + CW'(1'b1);
          end
          if (exit_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] read_cnt_r;

  // Total reads issued, wrapping; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_cnt_r <= 32'h0;
    end else if (stat_clr) begin
      read_cnt_r <= 32'h0;
    end else if (rd_s) begin
      read_cnt_r <= read_cnt_r + 32'h1;
    end
  end

  assign read_cnt = read_cnt_r;
`endif

endmodule
